// File: rtl/fmd_pkg.sv
// Shared types and limits for the multiply/divide normalize/round stage.
package fmd_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,
    RM_RZ  = 2'd1,
    RM_RU  = 2'd2,
    RM_RD  = 2'd3
  } rm_t;

  localparam int SIG_W = 57;
  localparam int FR_W  = 53;
  localparam int EXP_W = 13;
  localparam int NRM_W = 56;

  localparam logic signed [EXP_W-1:0] EMAX_D = 13'sd1023;
  localparam logic signed [EXP_W-1:0] EMIN_D = -13'sd1022;
  localparam logic signed [EXP_W-1:0] EMAX_S = 13'sd127;
  localparam logic signed [EXP_W-1:0] EMIN_S = -13'sd126;

  function automatic logic round_inc(input rm_t rm, input logic sign,
                                     input logic lsb, input logic g, input logic s);
    case (rm)
      RM_RNE:  return g & (s | lsb);
      RM_RZ:   return 1'b0;
      RM_RU:   return ~sign & (g | s);
      default: return sign & (g | s);
    endcase
  endfunction

endpackage

// File: rtl/fmd_lzc.sv
// 56-bit leading-zero counter, binary-search reduction over halving windows.
module fmd_lzc (
  input  logic [55:0] i_a,
  output logic [5:0]  o_cnt
);

  logic [63:0] w_v;

  // Padding the bottom with ones caps the count at 56 for an all-zero input.
  always_comb begin
    w_v   = {i_a, 8'hFF};
    o_cnt = '0;
    o_cnt[5] = ~|w_v[63:32];
    if (o_cnt[5]) w_v = w_v << 32;
    o_cnt[4] = ~|w_v[63:48];
    if (o_cnt[4]) w_v = w_v << 16;
    o_cnt[3] = ~|w_v[63:56];
    if (o_cnt[3]) w_v = w_v << 8;
    o_cnt[2] = ~|w_v[63:60];
    if (o_cnt[2]) w_v = w_v << 4;
    o_cnt[1] = ~|w_v[63:62];
    if (o_cnt[1]) w_v = w_v << 2;
    o_cnt[0] = ~w_v[63];
  end

endmodule

// File: rtl/fmd_round.sv
// Two-stage normalize (S1) and IEEE round (S2) pipeline behind the mul/div significand unit.
module fmd_round
  import fmd_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SIG_W-1:0]        fq,
  input  logic signed [EXP_W-1:0] er_in,
  input  logic                    sign,
  input  logic                    db,
  input  rm_t                     rm,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FR_W-1:0]         fr,
  output logic signed [EXP_W-1:0] er,
  output logic                    f_inx,
  output logic                    f_ovf,
  output logic                    f_unf,
  output logic                    f_zero
);

  logic w_s1_adv, w_s2_adv;
  logic r_s1_v, r_s2_v;

  assign w_s2_adv = ~r_s2_v | out_ready;
  assign w_s1_adv = ~r_s1_v | w_s2_adv;
  assign in_ready = w_s1_adv;

  // S1: normalize so the hidden bit lands at n[55]
  logic [5:0]              w_lz;
  logic [NRM_W-1:0]        w_n;
  logic signed [EXP_W-1:0] w_e;
  logic                    w_zero;

  fmd_lzc u_lzc (
    .i_a   (fq[55:0]),
    .o_cnt (w_lz)
  );

  always_comb begin
    w_zero = (fq == '0);
    w_n    = fq[55:0];
    w_e    = er_in;
    if (fq[56]) begin
      w_n = {fq[56:2], fq[1] | fq[0]};
      w_e = er_in + 13'sd1;
    end else if (!fq[55]) begin
      w_n = fq[55:0] << w_lz;
      w_e = er_in - $signed({7'd0, w_lz});
    end
  end

  logic [NRM_W-1:0]        r_s1_n;
  logic signed [EXP_W-1:0] r_s1_e;
  logic                    r_s1_zero, r_s1_db, r_s1_sign;
  rm_t                     r_s1_rm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v    <= 1'b0;
      r_s1_n    <= '0;
      r_s1_e    <= '0;
      r_s1_zero <= 1'b0;
      r_s1_db   <= 1'b0;
      r_s1_sign <= 1'b0;
      r_s1_rm   <= RM_RNE;
    end else if (w_s1_adv) begin
      r_s1_v <= in_valid;
      if (in_valid) begin
        r_s1_n    <= w_n;
        r_s1_e    <= w_e;
        r_s1_zero <= w_zero;
        r_s1_db   <= db;
        r_s1_sign <= sign;
        r_s1_rm   <= rm;
      end
    end
  end

  // S2: round at the precision selected by the operand's own db bit
  logic                    w_lsb, w_g, w_s, w_inc, w_carry;
  logic [53:0]             w_sum_d;
  logic [24:0]             w_sum_s;
  logic [FR_W-1:0]         w_fr;
  logic signed [EXP_W-1:0] w_e2, w_emax, w_emin;
  logic                    w_inx, w_ovf, w_unf;

  always_comb begin
    w_lsb   = r_s1_db ? r_s1_n[3] : r_s1_n[32];
    w_g     = r_s1_db ? r_s1_n[2] : r_s1_n[31];
    w_s     = r_s1_db ? |r_s1_n[1:0] : |r_s1_n[30:0];
    w_inc   = round_inc(r_s1_rm, r_s1_sign, w_lsb, w_g, w_s);
    w_sum_d = {1'b0, r_s1_n[55:3]} + 54'(w_inc);
    w_sum_s = {1'b0, r_s1_n[55:32]} + 25'(w_inc);
    w_carry = r_s1_db ? w_sum_d[53] : w_sum_s[24];
    if (w_carry)      w_fr = {1'b1, 52'd0};
    else if (r_s1_db) w_fr = w_sum_d[52:0];
    else              w_fr = {w_sum_s[23:0], 29'd0};
    w_e2   = r_s1_e + (w_carry ? 13'sd1 : 13'sd0);
    w_emax = r_s1_db ? EMAX_D : EMAX_S;
    w_emin = r_s1_db ? EMIN_D : EMIN_S;
    w_inx  = w_g | w_s;
    w_ovf  = w_e2 > w_emax;
    w_unf  = w_e2 < w_emin;
    if (r_s1_zero) begin
      w_fr  = '0;
      w_e2  = '0;
      w_inx = 1'b0;
      w_ovf = 1'b0;
      w_unf = 1'b0;
    end
  end

  logic [FR_W-1:0]         r_fr;
  logic signed [EXP_W-1:0] r_er;
  logic                    r_inx, r_ovf, r_unf, r_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_v <= 1'b0;
      r_fr   <= '0;
      r_er   <= '0;
      r_inx  <= 1'b0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_fr   <= w_fr;
        r_er   <= w_e2;
        r_inx  <= w_inx;
        r_ovf  <= w_ovf;
        r_unf  <= w_unf;
        r_zero <= r_s1_zero;
      end
    end
  end

  assign out_valid = r_s2_v;
  assign fr        = r_fr;
  assign er        = r_er;
  assign f_inx     = r_inx;
  assign f_ovf     = r_ovf;
  assign f_unf     = r_unf;
  assign f_zero    = r_zero;

endmodule
